// File: rtl/xor_pkg.sv
// Shared definitions for the streaming column-parity engine.
package xor_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Width of a counter that must represent 0..max inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// Reduction XOR of a WIDTH-bit word into a single parity bit.
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             par
);

    assign par = ^data;

endmodule

// File: rtl/xor_parity_frame.sv
// Frame-level XOR parity generator/checker with valid/ready on both sides.
// GEN emits the column parity of a frame; CHK folds the final (expected) word in and flags a non-zero residue.
module xor_parity_frame
    import xor_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode_chk,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_parity,
    output logic                           out_word_par,
    output logic                           out_err,
    output logic                           out_len_err,
    output logic [cnt_w(MAX_WORDS)-1:0]    out_count
);

    localparam int              CW       = cnt_w(MAX_WORDS);
    localparam logic [WIDTH-1:0] SEED    = (ODD != 0) ? '1 : '0;
    localparam logic [CW-1:0]    LAST_IDX = CW'(MAX_WORDS - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             mode_q;

    logic [WIDTH-1:0] nxt_parity;
    logic             nxt_word_par;
    logic             accept;
    logic             at_limit;
    logic             term;
    logic             cur_mode;

    assign nxt_parity = acc ^ in_data;
    assign accept     = in_valid && in_ready;
    assign at_limit   = (count == LAST_IDX);
    assign term       = in_last || at_limit;
    // The first word of a frame carries the mode; later words use the latched copy.
    assign cur_mode   = (count == '0) ? mode_chk : mode_q;

    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .data (nxt_parity),
        .par  (nxt_word_par)
    );

    // NOTE: every register is updated with non-blocking assignments so all
    // state advances together on the edge; blocking here would let later
    // statements see half-updated values and simulate differently from the
    // synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ACCUM;
            acc          <= SEED;
            count        <= '0;
            mode_q       <= MODE_GEN;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_parity   <= '0;
            out_word_par <= 1'b0;
            out_err      <= 1'b0;
            out_len_err  <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (count == '0) begin
                            mode_q <= mode_chk;
                        end
                        if (term) begin
                            out_parity   <= nxt_parity;
                            out_word_par <= nxt_word_par;
                            out_err      <= (cur_mode == MODE_CHK) && (|nxt_parity);
                            out_len_err  <= !in_last && at_limit;
                            out_count    <= count + CW'(1);
                            out_valid    <= 1'b1;
                            in_ready     <= 1'b0;
                            acc          <= SEED;
                            count        <= '0;
                            state        <= ST_HOLD;
                        end else begin
                            acc   <= nxt_parity;
                            count <= count + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Result is held until the consumer takes it; input stays stalled.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule
